// File: rtl/sparc_spu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : sparc_spu_mul_seq
// Purpose  : Upstream request sequencer for the SPARC multiplier SPU port.
//            Accepts one modular-multiply command, pulses an ACCUM reset,
//            then walks a column loop.  Each column issues a chain of
//            accumulate-multiply requests followed by one ACCUM >>64 shift
//            request.  Every request is held until the multiplier acks it.
//            Operand indices are exported so SPU operand storage can
//            present the matching words.
// Ports    :
//   rclk, rst_l              clock, synchronous active-low reset
//   cmd_vld/cmd_rdy          command handshake (cmd_rdy = idle)
//   cmd_nmac, cmd_ncol       MACs per column, number of columns
//   cmd_x2                   request x2 left shift on every product
//   abort                    cancel the command in progress
//   mul_spu_ack              multiplier accepted the MAC (same cycle)
//   mul_spu_shf_ack          multiplier performed the ACCUM shift
//   spu_mul_*                request outputs to the multiplier (Moore)
//   seq_mac_idx, seq_col_idx current operand indices
//   seq_busy, seq_done       status, one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module sparc_spu_mul_seq #(
    parameter int CNT_W = 4
) (
    input  logic             rclk,
    input  logic             rst_l,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [CNT_W-1:0] cmd_nmac,
    input  logic [CNT_W-1:0] cmd_ncol,
    input  logic             cmd_x2,
    input  logic             abort,
    input  logic             mul_spu_ack,
    input  logic             mul_spu_shf_ack,
    output logic             spu_mul_req_vld,
    output logic             spu_mul_acc,
    output logic             spu_mul_areg_shf,
    output logic             spu_mul_areg_rst,
    output logic             spu_mul_mulres_lshft,
    output logic [CNT_W-1:0] seq_mac_idx,
    output logic [CNT_W-1:0] seq_col_idx,
    output logic             seq_busy,
    output logic             seq_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARST = 3'd1,
        S_MAC  = 3'd2,
        S_SHF  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_ZERO = '0;
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_nmac, w_nmac_nxt;
    logic [CNT_W-1:0] r_ncol, w_ncol_nxt;
    logic             r_x2, w_x2_nxt;
    logic [CNT_W-1:0] r_mac_idx, w_mac_idx_nxt;
    logic [CNT_W-1:0] r_col_idx, w_col_idx_nxt;

    // Last-element compares use the latched counts; the loops are only
    // entered with a non-zero count, so nmac-1 / ncol-1 never underflow
    // in a state where the compare matters.
    logic w_mac_last;
    logic w_col_last;
    assign w_mac_last = (r_mac_idx == (r_nmac - C_ONE));
    assign w_col_last = (r_col_idx == (r_ncol - C_ONE));

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            r_state   <= S_IDLE;
            r_nmac    <= C_ZERO;
            r_ncol    <= C_ZERO;
            r_x2      <= 1'b0;
            r_mac_idx <= C_ZERO;
            r_col_idx <= C_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_nmac    <= w_nmac_nxt;
            r_ncol    <= w_ncol_nxt;
            r_x2      <= w_x2_nxt;
            r_mac_idx <= w_mac_idx_nxt;
            r_col_idx <= w_col_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_nmac_nxt    = r_nmac;
        w_ncol_nxt    = r_ncol;
        w_x2_nxt      = r_x2;
        w_mac_idx_nxt = r_mac_idx;
        w_col_idx_nxt = r_col_idx;

        case (r_state)
            S_IDLE: begin
                if (cmd_vld) begin
                    w_nmac_nxt    = cmd_nmac;
                    w_ncol_nxt    = cmd_ncol;
                    w_x2_nxt      = cmd_x2;
                    w_mac_idx_nxt = C_ZERO;
                    w_col_idx_nxt = C_ZERO;
                    w_state_nxt   = S_ARST;
                end
            end

            S_ARST: begin
                if (r_ncol == C_ZERO) begin
                    w_state_nxt = S_DONE;
                end else if (r_nmac == C_ZERO) begin
                    w_state_nxt = S_SHF;
                end else begin
                    w_state_nxt = S_MAC;
                end
            end

            S_MAC: begin
                if (mul_spu_ack) begin
                    if (w_mac_last) begin
                        w_mac_idx_nxt = C_ZERO;
                        w_state_nxt   = S_SHF;
                    end else begin
                        w_mac_idx_nxt = r_mac_idx + C_ONE;
                    end
                end
            end

            S_SHF: begin
                if (mul_spu_shf_ack) begin
                    if (w_col_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_col_idx_nxt = r_col_idx + C_ONE;
                        // A zero-MAC command is a pure shift loop.
                        w_state_nxt   = (r_nmac == C_ZERO) ? S_SHF : S_MAC;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt   = S_IDLE;
                w_mac_idx_nxt = C_ZERO;
                w_col_idx_nxt = C_ZERO;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over any same-cycle ack: the acked op finishes inside
        // the multiplier without being tracked here.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_mac_idx_nxt = C_ZERO;
            w_col_idx_nxt = C_ZERO;
        end
    end

    // Moore outputs; the states are exclusive so requests never overlap.
    assign cmd_rdy              = (r_state == S_IDLE);
    assign seq_busy             = (r_state != S_IDLE);
    assign spu_mul_areg_rst     = (r_state == S_ARST);
    assign spu_mul_req_vld      = (r_state == S_MAC);
    assign spu_mul_acc          = (r_state == S_MAC);
    assign spu_mul_mulres_lshft = (r_state == S_MAC) && r_x2;
    assign spu_mul_areg_shf     = (r_state == S_SHF);
    assign seq_done             = (r_state == S_DONE);
    assign seq_mac_idx          = r_mac_idx;
    assign seq_col_idx          = r_col_idx;

endmodule
`default_nettype wire

// File: tb/tb_sparc_spu_mul_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sparc_spu_mul_seq
// Purpose  : Self-checking bench for sparc_spu_mul_seq.  Issued commands are
//            expanded into the list of expected multiplier-side events;
//            a negedge monitor pops one entry per observed event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparc_spu_mul_seq;

    localparam int CNT_W = 4;

    localparam int K_ARST = 0;
    localparam int K_MAC  = 1;
    localparam int K_SHF  = 2;
    localparam int K_DONE = 3;

    logic             rclk = 1'b0;
    logic             rst_l;
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [CNT_W-1:0] cmd_nmac;
    logic [CNT_W-1:0] cmd_ncol;
    logic             cmd_x2;
    logic             abort;
    logic             mul_spu_ack;
    logic             mul_spu_shf_ack;
    logic             spu_mul_req_vld;
    logic             spu_mul_acc;
    logic             spu_mul_areg_shf;
    logic             spu_mul_areg_rst;
    logic             spu_mul_mulres_lshft;
    logic [CNT_W-1:0] seq_mac_idx;
    logic [CNT_W-1:0] seq_col_idx;
    logic             seq_busy;
    logic             seq_done;

    always #5 rclk = ~rclk;

    sparc_spu_mul_seq #(.CNT_W(CNT_W)) dut (
        .rclk                 (rclk),
        .rst_l                (rst_l),
        .cmd_vld              (cmd_vld),
        .cmd_rdy              (cmd_rdy),
        .cmd_nmac             (cmd_nmac),
        .cmd_ncol             (cmd_ncol),
        .cmd_x2               (cmd_x2),
        .abort                (abort),
        .mul_spu_ack          (mul_spu_ack),
        .mul_spu_shf_ack      (mul_spu_shf_ack),
        .spu_mul_req_vld      (spu_mul_req_vld),
        .spu_mul_acc          (spu_mul_acc),
        .spu_mul_areg_shf     (spu_mul_areg_shf),
        .spu_mul_areg_rst     (spu_mul_areg_rst),
        .spu_mul_mulres_lshft (spu_mul_mulres_lshft),
        .seq_mac_idx          (seq_mac_idx),
        .seq_col_idx          (seq_col_idx),
        .seq_busy             (seq_busy),
        .seq_done             (seq_done)
    );

    typedef struct {
        int kind;
        int mac;
        int col;
        int x2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command is ARST, then per column nmac MACs and one
    // shift, then DONE.
    task automatic push_cmd(input int nm, input int nc, input int x2);
        exp_t e;
        e = '{K_ARST, 0, 0, 0};
        sb.push_back(e);
        for (int c = 0; c < nc; c++) begin
            for (int m = 0; m < nm; m++) begin
                e = '{K_MAC, m, c, x2};
                sb.push_back(e);
            end
            e = '{K_SHF, 0, c, 0};
            sb.push_back(e);
        end
        e = '{K_DONE, 0, 0, 0};
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int kind, input int mac, input int col, input int x2);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == K_MAC && kind == K_MAC) begin
                chk("mac_idx", mac, e.mac);
                chk("mac_col_idx", col, e.col);
                chk("mac_lshft", x2, e.x2);
            end
            if (e.kind == K_SHF && kind == K_SHF) begin
                chk("shf_col_idx", col, e.col);
            end
        end
    endtask

    // ---------------- monitor ----------------
    bit exp_idle = 0;
    bit pend_mac = 0;
    bit pend_shf = 0;
    int pm_mac, pm_col, pm_x2, ps_col;

    always @(negedge rclk) begin
        if (!rst_l) begin
            sb.delete();
            exp_idle = 1;
            pend_mac = 0;
            pend_shf = 0;
        end else begin
            if (exp_idle) begin
                chk("idle_cmd_rdy", int'(cmd_rdy), 1);
                chk("idle_outputs", int'({spu_mul_req_vld, spu_mul_acc, spu_mul_areg_shf,
                    spu_mul_areg_rst, spu_mul_mulres_lshft, seq_busy, seq_done}), 0);
                chk("idle_indices", int'({seq_mac_idx, seq_col_idx}), 0);
                exp_idle = 0;
            end
            if (pend_mac) begin
                chk("mac_hold_vld", int'(spu_mul_req_vld), 1);
                chk("mac_hold_idx", int'(seq_mac_idx), pm_mac);
                chk("mac_hold_col", int'(seq_col_idx), pm_col);
                chk("mac_hold_lshft", int'(spu_mul_mulres_lshft), pm_x2);
            end
            if (pend_shf) begin
                chk("shf_hold_vld", int'(spu_mul_areg_shf), 1);
                chk("shf_hold_col", int'(seq_col_idx), ps_col);
            end
            chk("req_onehot", int'($countones({spu_mul_req_vld, spu_mul_areg_shf,
                spu_mul_areg_rst, seq_done}) <= 1), 1);
            chk("busy_vs_rdy", int'(seq_busy), int'(!cmd_rdy));
            chk("acc_vs_req", int'(spu_mul_acc), int'(spu_mul_req_vld));
            if (!spu_mul_req_vld) chk("lshft_no_req", int'(spu_mul_mulres_lshft), 0);
            pend_mac = 0;
            pend_shf = 0;
            if (abort && seq_busy) begin
                sb.delete();
                exp_idle = 1;
            end else begin
                if (spu_mul_areg_rst) pop_chk(K_ARST, 0, 0, 0);
                if (spu_mul_req_vld) begin
                    if (mul_spu_ack) begin
                        pop_chk(K_MAC, int'(seq_mac_idx), int'(seq_col_idx),
                                int'(spu_mul_mulres_lshft));
                    end else begin
                        pend_mac = 1;
                        pm_mac   = int'(seq_mac_idx);
                        pm_col   = int'(seq_col_idx);
                        pm_x2    = int'(spu_mul_mulres_lshft);
                    end
                end
                if (spu_mul_areg_shf) begin
                    if (mul_spu_shf_ack) begin
                        pop_chk(K_SHF, 0, int'(seq_col_idx), 0);
                    end else begin
                        pend_shf = 1;
                        ps_col   = int'(seq_col_idx);
                    end
                end
                if (seq_done) pop_chk(K_DONE, 0, 0, 0);
            end
        end
    end

    // ---------------- stimulus / multiplier model ----------------
    int mac_dly = 0, shf_dly = 0;
    bit rnd_dly = 0;
    int mac_wait = 0, shf_wait = 0, mac_tgt = 0, shf_tgt = 0;

    function automatic int pick(input int fixed);
        return rnd_dly ? int'($urandom_range(0, 3)) : fixed;
    endfunction

    task automatic set_mode(input int md, input int sd, input bit rnd);
        mac_dly = md;
        shf_dly = sd;
        rnd_dly = rnd;
        mac_tgt = pick(md);
        shf_tgt = pick(sd);
        mac_wait = 0;
        shf_wait = 0;
    endtask

    // Advance one clock; acks are returned after the configured number of
    // request cycles.
    task automatic step();
        @(posedge rclk);
        #1;
        if (spu_mul_req_vld) begin
            if (mac_wait >= mac_tgt) begin
                mul_spu_ack = 1'b1;
                mac_wait    = 0;
                mac_tgt     = pick(mac_dly);
            end else begin
                mul_spu_ack = 1'b0;
                mac_wait++;
            end
        end else begin
            mul_spu_ack = 1'b0;
            mac_wait    = 0;
        end
        if (spu_mul_areg_shf) begin
            if (shf_wait >= shf_tgt) begin
                mul_spu_shf_ack = 1'b1;
                shf_wait        = 0;
                shf_tgt         = pick(shf_dly);
            end else begin
                mul_spu_shf_ack = 1'b0;
                shf_wait++;
            end
        end else begin
            mul_spu_shf_ack = 1'b0;
            shf_wait        = 0;
        end
    endtask

    task automatic issue(input int nm, input int nc, input int x2);
        int i;
        for (i = 0; i < 200 && !cmd_rdy; i++) step();
        if (!cmd_rdy) chk("issue_timeout", 0, 1);
        push_cmd(nm, nc, x2);
        cmd_nmac = CNT_W'(nm);
        cmd_ncol = CNT_W'(nc);
        cmd_x2   = x2[0];
        cmd_vld  = 1'b1;
        step();
        cmd_vld  = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (cmd_rdy && sb.size() == 0) break;
            step();
        end
        if (!(cmd_rdy && sb.size() == 0)) chk("done_timeout", 0, 1);
    endtask

    task automatic run_cmd(input int nm, input int nc, input int x2);
        issue(nm, nc, x2);
        wait_done();
    endtask

    initial begin
        int i;
        rst_l           = 1'b0;
        cmd_vld         = 1'b0;
        cmd_nmac        = '0;
        cmd_ncol        = '0;
        cmd_x2          = 1'b0;
        abort           = 1'b0;
        mul_spu_ack     = 1'b0;
        mul_spu_shf_ack = 1'b0;
        repeat (3) step();
        rst_l = 1'b1;
        step();

        // 1: immediate MAC acks, shift ack two cycles late
        set_mode(0, 2, 0);
        run_cmd(2, 1, 0);

        // 2: every op delayed two cycles, x2 set
        set_mode(2, 2, 0);
        run_cmd(3, 2, 1);

        // 3: zero columns
        set_mode(0, 0, 0);
        run_cmd(5, 0, 1);

        // 4: zero MACs, three columns
        set_mode(0, 1, 0);
        run_cmd(0, 3, 0);

        // 5: abort coincident with the ack of column 1, MAC 1
        set_mode(1, 0, 0);
        issue(3, 2, 0);
        for (i = 0; i < 300; i++) begin
            if (spu_mul_req_vld && seq_col_idx == 1 && seq_mac_idx == 1) break;
            step();
        end
        chk("abort_target_found", int'(spu_mul_req_vld && seq_col_idx == 1 && seq_mac_idx == 1), 1);
        mul_spu_ack = 1'b1;
        abort       = 1'b1;
        step();
        abort = 1'b0;
        run_cmd(1, 1, 1);

        // 6: reset mid-shift with cmd_vld held while busy
        set_mode(0, 20, 0);
        issue(1, 2, 0);
        cmd_vld = 1'b1;
        for (i = 0; i < 100 && !spu_mul_areg_shf; i++) step();
        chk("shf_reached", int'(spu_mul_areg_shf), 1);
        step();
        step();
        cmd_vld = 1'b0;
        rst_l   = 1'b0;
        step();
        rst_l = 1'b1;
        step();

        // random traffic
        set_mode(0, 0, 1);
        for (int n = 0; n < 25; n++) begin
            run_cmd(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 1)));
        end
        step();
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
